mvu_job_sequencer: RTL and testbench
====================================

# mvu_job_sequencer

Upstream control stage for `mvutop`. It accepts MVU job descriptors from a host/controller over a valid/ready port and queues them in a small FIFO. It drives the MVU configuration bus and start strobe one job at a time, waits for the MVU completion pulse or a programmable timeout, and returns a per-job status record. It removes host-side polling and guarantees configuration is held stable for the whole job.

## Interface
Parameters:
- `QDEPTH`, 4: descriptor FIFO depth; power of two, ≥2.
- `AW`, 15: memory base-address width.
- `CNTW`, 15: job iteration-count width.
- `TOW`, 20: timeout counter width.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  descriptor offered.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_desc`  in  `$bits(mvu_job_t)`  descriptor.
- `mvu_cfg`  out  `$bits(mvu_job_t)`  configuration to MVU, registered.
- `mvu_start`  out  1  one-cycle start pulse.
- `mvu_done`  in  1  MVU completion pulse (irq).
- `timeout_cycles`  in  TOW  BUSY-cycle limit; 0 disables timeout.
- `stat_valid`  out  1  status record available.
- `stat_ready`  in  1  status consumer ready.
- `stat_tag`  out  4  tag of the finished job.
- `stat_timeout`  out  1  job ended by timeout.
- `stat_err`  out  1  descriptor rejected, MVU not started.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.

## Operation
- `mvu_job_t` fields: `tag[3:0]`, `wprec[3:0]`, `iprec[3:0]`, `oprec[3:0]`, `wbase[AW]`, `ibase[AW]`, `obase[AW]`, `countm1[CNTW]`.
- A descriptor is pushed on a cycle where `cmd_valid && cmd_ready` is true.
- `cmd_ready = !full`. There is no bypass: a push is never accepted at full, even when a pop occurs in the same cycle.
- A descriptor is valid when `wprec`, `iprec` and `oprec` are each in 1..8. Any other value sets `stat_err`.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop and latch the head into `mvu_cfg`, then go to LOAD.
  - LOAD: run the validity check. Invalid goes to REPORT with `err=1`; valid goes to START.
  - START: `mvu_start=1` for exactly this cycle; clear the timer; go to BUSY.
  - BUSY: the timer increments every cycle, reading 1 in the first BUSY cycle.
    - `mvu_done` goes to REPORT.
    - If `timeout_cycles != 0` and timer equals `timeout_cycles`, go to REPORT with `timeout=1`.
    - If done and timeout occur in the same cycle, done wins and `timeout=0`.
  - REPORT: `stat_valid=1`; status fields held stable until `stat_ready`, then go to IDLE.
- `mvu_done` outside BUSY is ignored.
- `mvu_cfg` holds from latch until the next pop. It is never changed while in START, BUSY or REPORT.
- Pushes continue freely while a job runs.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - State IDLE, FIFO empty, timer 0.
  - `cmd_ready=1`; `mvu_cfg=0`.
  - `mvu_start`, `stat_valid`, `stat_tag`, `stat_timeout`, `stat_err`, `busy` all 0.
- Reset mid-job drops the current job and all queued descriptors. No status is produced for them.
- Empty-queue latency: a push accepted at the edge ending cycle t gives LOAD in t+2 and `mvu_start` high in t+3.
- Back-to-back jobs: with `stat_ready` held high, REPORT lasts 1 cycle and IDLE 1 cycle. The next `mvu_start` comes 3 cycles after the REPORT cycle.
- FIFO pointers are `log2(QDEPTH)+1` bits wide and wrap modulo 2·QDEPTH. Full and empty are distinguished by the MSB.

## Structure
- Package `mvu_pkg` holds `mvu_job_t` and the state enum `seq_state_e` (IDLE, LOAD, START, BUSY, REPORT).
- Package `mvu_pkg` also holds the constants `MVU_PREC_MIN=1` and `MVU_PREC_MAX=8`.
- Sub-module `mvu_job_fifo` provides a synchronous FIFO of `mvu_job_t` with push/pop, full/empty, and `rst_n` clearing.
- The FSM, timer and status register live in `mvu_job_sequencer`.

## Test plan
- Single job: push tag=3, precisions 2/2/2. `mvu_start` is high 3 cycles after acceptance, with `mvu_cfg` equal to the descriptor. Pulse `mvu_done` 40 cycles later. The next cycle gives `stat_valid=1`, tag=3, timeout=0, err=0.
- Fill/overflow: hold `stat_ready=0` and push 6 descriptors. The first goes straight to execution. `cmd_ready` drops after 4 more are queued. The 6th is held until a pop, and all tags complete in order.
- Timeout: set `timeout_cycles=5` and never pulse done. REPORT follows the 5th BUSY cycle with timeout=1. Repeat with done on the 5th BUSY cycle: timeout=0.
- Invalid descriptor: `wprec=0` or `oprec=9` gives `stat_err=1` and `mvu_start` is never asserted. The following valid job runs normally.
- Status backpressure: hold `stat_ready=0` for 10 cycles during REPORT. The status fields stay stable, and a stray `mvu_done` in REPORT is ignored.
- Reset mid-job: assert `rst_n=0` during BUSY with 2 jobs queued. Outputs clear immediately, `cmd_ready=1`, and no stale status or start appears after release.

Source files
------------

// File: rtl/mvu_pkg.sv
// Shared types and constants for the MVU job sequencer: descriptor layout,
// sequencer states and precision limits.
package mvu_pkg;

  localparam int unsigned MVU_AW   = 15;
  localparam int unsigned MVU_CNTW = 15;

  localparam logic [3:0] MVU_PREC_MIN = 4'd1;
  localparam logic [3:0] MVU_PREC_MAX = 4'd8;

  typedef struct packed {
    logic [3:0]          tag;
    logic [3:0]          wprec;
    logic [3:0]          iprec;
    logic [3:0]          oprec;
    logic [MVU_AW-1:0]   wbase;
    logic [MVU_AW-1:0]   ibase;
    logic [MVU_AW-1:0]   obase;
    logic [MVU_CNTW-1:0] countm1;
  } mvu_job_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    BUSY,
    REPORT
  } seq_state_e;

  function automatic logic prec_ok(input logic [3:0] p);
    return (p >= MVU_PREC_MIN) && (p <= MVU_PREC_MAX);
  endfunction

  function automatic logic job_valid(input mvu_job_t j);
    return prec_ok(j.wprec) && prec_ok(j.iprec) && prec_ok(j.oprec);
  endfunction

endpackage

// File: rtl/mvu_job_fifo.sv
// Descriptor queue: power-of-two synchronous FIFO with wrap-bit pointers so
// full and empty are told apart by the pointer MSB.
module mvu_job_fifo
  import mvu_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  mvu_job_t push_data,
  input  logic     pop,
  output mvu_job_t head_c,
  output logic     full_c,
  output logic     empty_c
);

  localparam int unsigned IW = $clog2(QDEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  mvu_job_t      mem [QDEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr == {~rd_ptr[PW-1], rd_ptr[PW-2:0]});
  assign head_c  = mem[rd_ptr[IW-1:0]];
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; the cleared pointers make old entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mvu_job_sequencer.sv
// Queues MVU job descriptors and runs them one at a time: holds the config,
// pulses start, waits for done or timeout, and reports a status record.
module mvu_job_sequencer
  import mvu_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned AW     = 15,
  parameter int unsigned CNTW   = 15,
  parameter int unsigned TOW    = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [16+3*AW+CNTW-1:0] cmd_desc,
  output logic [16+3*AW+CNTW-1:0] mvu_cfg,
  output logic                    mvu_start,
  input  logic                    mvu_done,
  input  logic [TOW-1:0]          timeout_cycles,
  output logic                    stat_valid,
  input  logic                    stat_ready,
  output logic [3:0]              stat_tag,
  output logic                    stat_timeout,
  output logic                    stat_err,
  output logic                    busy
);

  seq_state_e     state_q, state_d;
  mvu_job_t       desc_in, fifo_head, cfg_q, cfg_d;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [TOW-1:0] timer_q;
  logic [3:0]     tag_d;
  logic           timeout_d, err_d;
  logic           timer_hit;

  assign desc_in   = mvu_job_t'(cmd_desc);
  assign cmd_ready = !fifo_full;
  assign mvu_cfg   = cfg_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign timer_hit = (timeout_cycles != '0) && (timer_q == timeout_cycles);

  mvu_job_fifo #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cmd_valid),
    .push_data(desc_in),
    .pop      (fifo_pop),
    .head_c   (fifo_head),
    .full_c   (fifo_full),
    .empty_c  (fifo_empty)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    tag_d     = stat_tag;
    timeout_d = stat_timeout;
    err_d     = stat_err;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cfg_d    = fifo_head;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (job_valid(cfg_q)) begin
          state_d = START;
        end else begin
          state_d   = REPORT;
          tag_d     = cfg_q.tag;
          timeout_d = 1'b0;
          err_d     = 1'b1;
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        // Completion takes priority over a coincident timeout.
        if (mvu_done || timer_hit) begin
          state_d   = REPORT;
          tag_d     = cfg_q.tag;
          timeout_d = !mvu_done;
          err_d     = 1'b0;
        end
      end
      REPORT: begin
        if (stat_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      timer_q      <= '0;
      mvu_start    <= 1'b0;
      stat_valid   <= 1'b0;
      stat_tag     <= '0;
      stat_timeout <= 1'b0;
      stat_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      mvu_start    <= (state_d == START);
      stat_valid   <= (state_d == REPORT);
      stat_tag     <= tag_d;
      stat_timeout <= timeout_d;
      stat_err     <= err_d;
      // Loading 1 on leaving START makes the timer read 1 in the first BUSY cycle.
      if (state_q == START)     timer_q <= TOW'(1);
      else if (state_q == BUSY) timer_q <= timer_q + TOW'(1);
    end
  end

endmodule

// File: tb/tb_mvu_job_sequencer.sv
// Self-checking bench for mvu_job_sequencer: directed scenarios plus a
// randomized run checked against a queue-based job model.
module tb_mvu_job_sequencer;
  import mvu_pkg::*;

  localparam int unsigned QDEPTH = 4;
  localparam int unsigned AW     = 15;
  localparam int unsigned CNTW   = 15;
  localparam int unsigned TOW    = 20;
  localparam int unsigned JW     = $bits(mvu_job_t);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [JW-1:0]  cmd_desc = '0;
  logic [JW-1:0]  mvu_cfg;
  logic           mvu_start;
  logic           mvu_done = 1'b0;
  logic [TOW-1:0] timeout_cycles = '0;
  logic           stat_valid;
  logic           stat_ready = 1'b0;
  logic [3:0]     stat_tag;
  logic           stat_timeout;
  logic           stat_err;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  mvu_job_t acc_q[$];

  mvu_job_sequencer #(
    .QDEPTH(QDEPTH), .AW(AW), .CNTW(CNTW), .TOW(TOW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_desc(cmd_desc), .mvu_cfg(mvu_cfg), .mvu_start(mvu_start),
    .mvu_done(mvu_done), .timeout_cycles(timeout_cycles),
    .stat_valid(stat_valid), .stat_ready(stat_ready), .stat_tag(stat_tag),
    .stat_timeout(stat_timeout), .stat_err(stat_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic mvu_job_t mk_desc(input logic [3:0] tag, input logic [3:0] wp,
                                       input logic [3:0] ip, input logic [3:0] op);
    mvu_job_t j;
    j.tag     = tag;
    j.wprec   = wp;
    j.iprec   = ip;
    j.oprec   = op;
    j.wbase   = MVU_AW'($urandom);
    j.ibase   = MVU_AW'($urandom);
    j.obase   = MVU_AW'($urandom);
    j.countm1 = MVU_CNTW'($urandom);
    return j;
  endfunction

  function automatic bit desc_ok(input mvu_job_t j);
    return (j.wprec >= 1 && j.wprec <= 8) && (j.iprec >= 1 && j.iprec <= 8) &&
           (j.oprec >= 1 && j.oprec <= 8);
  endfunction

  function automatic logic [3:0] rand_prec();
    int r;
    r = $urandom_range(0, 11);
    if (r == 0) return 4'd0;
    if (r == 1) return 4'($urandom_range(9, 15));
    return 4'($urandom_range(1, 8));
  endfunction

  function automatic logic [3:0] cfg_tag();
    mvu_job_t c;
    c = mvu_cfg;
    return c.tag;
  endfunction

  // Advance one clock; record a descriptor in the model when the handshake fires.
  task automatic step();
    bit acc;
    mvu_job_t j;
    acc = cmd_valid && cmd_ready;
    j   = cmd_desc;
    @(posedge clk); #1;
    if (acc) begin
      acc_q.push_back(j);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_start(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (mvu_start) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cmd_ready, mvu_start, stat_valid, stat_tag, stat_timeout, stat_err, busy} !== 10'b1_0_0_0000_0_0_0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 1000000000",
               {cmd_ready, mvu_start, stat_valid, stat_tag, stat_timeout, stat_err, busy});
    end
    n_checks++;
    if (mvu_cfg !== '0) begin
      n_fail++; $display("FAIL reset_cfg: got %h expected 0", mvu_cfg);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({cmd_ready, busy, mvu_start} !== 3'b100) begin
      n_fail++; $display("FAIL reset_release: got %b expected 100", {cmd_ready, busy, mvu_start});
    end
  endtask

  task automatic test_single_job();
    mvu_job_t d;
    d = mk_desc(4'd3, 4'd2, 4'd2, 4'd2);
    timeout_cycles = '0; stat_ready = 1'b1;
    cmd_desc = d; cmd_valid = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", cmd_ready); end
    step();
    step();
    n_checks++;
    if (mvu_start !== 1'b0) begin n_fail++; $display("FAIL single_early_start: got %b expected 0", mvu_start); end
    step();
    n_checks++;
    if (mvu_start !== 1'b1 || mvu_cfg !== d) begin
      n_fail++; $display("FAIL single_start: got start=%b cfg=%h expected start=1 cfg=%h", mvu_start, mvu_cfg, d);
    end
    for (int i = 1; i <= 40; i++) begin
      step();
      mvu_done = (i == 40);
      if (i == 1) begin
        n_checks++;
        if (mvu_start !== 1'b0) begin n_fail++; $display("FAIL single_start_width: got %b expected 0", mvu_start); end
      end
    end
    step();
    mvu_done = 1'b0;
    n_checks++;
    if ({stat_valid, stat_tag, stat_timeout, stat_err} !== {1'b1, 4'd3, 1'b0, 1'b0} || mvu_cfg !== d) begin
      n_fail++; $display("FAIL single_status: got v=%b tag=%0d to=%b err=%b expected v=1 tag=3 to=0 err=0",
                         stat_valid, stat_tag, stat_timeout, stat_err);
    end
    step();
    n_checks++;
    if ({stat_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_idle: got valid=%b busy=%b expected 0 0", stat_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    stat_ready = 1'b1; timeout_cycles = '0;
    cmd_desc = mk_desc(4'd4, 4'd1, 4'd1, 4'd1); cmd_valid = 1'b1; step();
    cmd_desc = mk_desc(4'd5, 4'd3, 4'd5, 4'd7); cmd_valid = 1'b1; step();
    wait_start(10, ok);
    n_checks++;
    if (!ok || cfg_tag() !== 4'd4) begin n_fail++; $display("FAIL b2b_first_start: got ok=%b tag=%0d expected 1 4", ok, cfg_tag()); end
    step(); mvu_done = 1'b1;
    step(); mvu_done = 1'b0;
    n_checks++;
    if ({stat_valid, stat_tag} !== {1'b1, 4'd4}) begin
      n_fail++; $display("FAIL b2b_report: got v=%b tag=%0d expected 1 4", stat_valid, stat_tag);
    end
    step();
    n_checks++;
    if ({stat_valid, mvu_start} !== 2'b00) begin n_fail++; $display("FAIL b2b_gap1: got %b expected 00", {stat_valid, mvu_start}); end
    step();
    n_checks++;
    if (mvu_start !== 1'b0) begin n_fail++; $display("FAIL b2b_gap2: got %b expected 0", mvu_start); end
    step();
    n_checks++;
    if (mvu_start !== 1'b1 || cfg_tag() !== 4'd5) begin
      n_fail++; $display("FAIL b2b_second_start: got start=%b tag=%0d expected 1 5", mvu_start, cfg_tag());
    end
    step(); mvu_done = 1'b1;
    step(); mvu_done = 1'b0;
    n_checks++;
    if ({stat_valid, stat_tag, stat_err} !== {1'b1, 4'd5, 1'b0}) begin
      n_fail++; $display("FAIL b2b_report2: got v=%b tag=%0d err=%b expected 1 5 0", stat_valid, stat_tag, stat_err);
    end
    step();
  endtask

  task automatic test_fill_overflow();
    mvu_job_t dv[6];
    int starts;
    bit ok;
    acc_q.delete();
    stat_ready = 1'b0; timeout_cycles = '0; mvu_done = 1'b0; starts = 0;
    for (int k = 0; k < 6; k++)
      dv[k] = mk_desc(4'(k), 4'($urandom_range(1, 8)), 4'($urandom_range(1, 8)), 4'($urandom_range(1, 8)));
    for (int k = 0; k < 5; k++) begin
      cmd_desc = dv[k]; cmd_valid = 1'b1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b expected 1", k, cmd_ready); end
      step();
      if (mvu_start) starts++;
    end
    cmd_desc = dv[5]; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_%0d: got %b expected 0", i, cmd_ready); end
      step();
      if (mvu_start) starts++;
    end
    n_checks++;
    if (starts != 1 || acc_q.size() != 5) begin
      n_fail++; $display("FAIL fill_counts: got starts=%0d accepted=%0d expected 1 5", starts, acc_q.size());
    end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        wait_start(30, ok);
        n_checks++;
        if (!ok || cfg_tag() !== 4'(k)) begin
          n_fail++; $display("FAIL fill_start_%0d: got ok=%b tag=%0d expected 1 %0d", k, ok, cfg_tag(), k);
        end
      end
      repeat (2) step();
      mvu_done = 1'b1; step(); mvu_done = 1'b0;
      n_checks++;
      if ({stat_valid, stat_tag} !== {1'b1, 4'(k)}) begin
        n_fail++; $display("FAIL fill_status_%0d: got v=%b tag=%0d expected 1 %0d", k, stat_valid, stat_tag, k);
      end
      if (k == 0) begin
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_in_report: got %b expected 0", cmd_ready); end
      end
      step(); step();
      stat_ready = 1'b1; step(); stat_ready = 1'b0;
    end
    step();
    n_checks++;
    if (acc_q.size() != 6 || busy !== 1'b0) begin
      n_fail++; $display("FAIL fill_end: got accepted=%0d busy=%b expected 6 0", acc_q.size(), busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic et;
    timeout_cycles = TOW'(5); stat_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      et = (r == 0);
      cmd_desc = mk_desc(4'(7 + r), 4'd8, 4'd1, 4'd4); cmd_valid = 1'b1; step();
      wait_start(10, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL timeout_start_%0d: got 0 expected 1", r); end
      for (int i = 1; i <= 5; i++) begin
        step();
        mvu_done = (r == 1 && i == 5);
        if (i == 5) begin
          n_checks++;
          if (stat_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_early_%0d: got %b expected 0", r, stat_valid); end
        end
      end
      step(); mvu_done = 1'b0;
      n_checks++;
      if ({stat_valid, stat_tag, stat_timeout, stat_err} !== {1'b1, 4'(7 + r), et, 1'b0}) begin
        n_fail++; $display("FAIL timeout_status_%0d: got v=%b tag=%0d to=%b err=%b expected 1 %0d %b 0",
                           r, stat_valid, stat_tag, stat_timeout, stat_err, 7 + r, et);
      end
      stat_ready = 1'b1; step(); stat_ready = 1'b0;
    end
    timeout_cycles = '0;
  endtask

  task automatic test_invalid();
    logic [3:0] etag[3] = '{4'd9, 4'd10, 4'd11};
    logic       eerr[3] = '{1'b1, 1'b1, 1'b0};
    int s, nstart, since, cyc;
    bit started;
    stat_ready = 1'b1; timeout_cycles = '0;
    cmd_desc = mk_desc(4'd9, 4'd0, 4'd3, 4'd3);  cmd_valid = 1'b1; step();
    cmd_desc = mk_desc(4'd10, 4'd3, 4'd3, 4'd9); cmd_valid = 1'b1; step();
    cmd_desc = mk_desc(4'd11, 4'd1, 4'd8, 4'd2); cmd_valid = 1'b1; step();
    s = 0; nstart = 0; since = 0; started = 1'b0; cyc = 0;
    while (s < 3 && cyc < 80) begin
      if (mvu_start) begin
        nstart++; started = 1'b1; since = 0;
        n_checks++;
        if (s != 2 || cfg_tag() !== 4'd11) begin
          n_fail++; $display("FAIL invalid_start: got reports=%0d tag=%0d expected 2 11", s, cfg_tag());
        end
      end else if (started) begin
        since++;
      end
      mvu_done = started && (since == 3);
      if (stat_valid) begin
        n_checks++;
        if ({stat_tag, stat_timeout, stat_err} !== {etag[s], 1'b0, eerr[s]}) begin
          n_fail++; $display("FAIL invalid_status_%0d: got tag=%0d to=%b err=%b expected %0d 0 %b",
                             s, stat_tag, stat_timeout, stat_err, etag[s], eerr[s]);
        end
        s++;
      end
      step(); cyc++;
    end
    mvu_done = 1'b0;
    n_checks++;
    if (s != 3 || nstart != 1) begin
      n_fail++; $display("FAIL invalid_counts: got reports=%0d starts=%0d expected 3 1", s, nstart);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    stat_ready = 1'b0; timeout_cycles = '0;
    cmd_desc = mk_desc(4'd12, 4'd4, 4'd4, 4'd4); cmd_valid = 1'b1; step();
    wait_start(10, ok);
    step(); mvu_done = 1'b1;
    step(); mvu_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({stat_valid, stat_tag, stat_timeout, stat_err, mvu_start} !== {1'b1, 4'd12, 1'b0, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold_%0d: got v=%b tag=%0d to=%b err=%b start=%b expected 1 12 0 0 0",
                           i, stat_valid, stat_tag, stat_timeout, stat_err, mvu_start);
      end
      mvu_done = (i == 4);
      step();
    end
    mvu_done = 1'b0;
    stat_ready = 1'b1; step(); stat_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({stat_valid, mvu_start, busy} !== 3'b000) begin
        n_fail++; $display("FAIL bp_after_%0d: got %b expected 000", i, {stat_valid, mvu_start, busy});
      end
      step();
    end
  endtask

  task automatic test_reset_midjob();
    bit ok;
    stat_ready = 1'b1; timeout_cycles = '0;
    for (int k = 1; k <= 3; k++) begin
      cmd_desc = mk_desc(4'(k), 4'd2, 4'd2, 4'd2); cmd_valid = 1'b1; step();
    end
    wait_start(10, ok);
    step(); step();
    n_checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstjob_busy: got busy=%b ready=%b expected 1 1", busy, cmd_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, mvu_start, stat_valid, stat_tag, stat_timeout, stat_err, busy} !== 10'b1_0_0_0000_0_0_0 ||
        mvu_cfg !== '0) begin
      n_fail++; $display("FAIL rstjob_clear: got %b cfg=%h expected 1000000000 cfg=0",
                         {cmd_ready, mvu_start, stat_valid, stat_tag, stat_timeout, stat_err, busy}, mvu_cfg);
    end
    acc_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mvu_done = (i % 5 == 2);
      n_checks++;
      if ({mvu_start, stat_valid, cmd_ready, busy} !== 4'b0010) begin
        n_fail++; $display("FAIL rstjob_after_%0d: got %b expected 0010", i, {mvu_start, stat_valid, cmd_ready, busy});
      end
      step();
    end
    mvu_done = 1'b0;
  endtask

  task automatic test_random();
    mvu_job_t pend[$];
    mvu_job_t j, c;
    int n, stat_idx, bcnt, dsel, tsel, end_c, cyc;
    bit active, cur_to, report_due, eerr, eto;
    n = 16; stat_idx = 0; bcnt = 0; dsel = 0; tsel = 0; end_c = 0; cyc = 0;
    active = 1'b0; cur_to = 1'b0; report_due = 1'b0;
    acc_q.delete();
    for (int i = 0; i < n; i++) pend.push_back(mk_desc(4'(i), rand_prec(), rand_prec(), rand_prec()));
    cmd_valid = 1'b0; stat_ready = 1'b0; mvu_done = 1'b0;
    while (stat_idx < n && cyc < 6000) begin
      if (!cmd_valid && pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        cmd_desc = pend.pop_front(); cmd_valid = 1'b1;
      end
      if (mvu_start) begin
        c = mvu_cfg;
        n_checks++;
        if (stat_idx >= acc_q.size() || !desc_ok(acc_q[stat_idx]) || c !== acc_q[stat_idx]) begin
          n_fail++; $display("FAIL rand_start: got tag=%0d expected job index %0d", c.tag, stat_idx);
        end
        tsel = $urandom_range(0, 8);
        dsel = (tsel == 0) ? $urandom_range(1, 12) : $urandom_range(0, 12);
        cur_to = (tsel != 0) && (dsel == 0 || tsel < dsel);
        end_c = cur_to ? tsel : dsel;
        timeout_cycles = TOW'(tsel);
        active = 1'b1; bcnt = 0;
      end else if (active) begin
        bcnt++;
      end
      if (report_due) begin
        n_checks++;
        if (stat_valid !== 1'b1) begin n_fail++; $display("FAIL rand_report_latency: got %b expected 1", stat_valid); end
        report_due = 1'b0;
      end
      mvu_done = active ? (dsel != 0 && bcnt == dsel) : ($urandom_range(0, 9) == 0);
      if (active && bcnt != 0 && bcnt == end_c) begin
        active = 1'b0; report_due = 1'b1;
      end
      stat_ready = ($urandom_range(0, 3) != 0);
      if (stat_valid && stat_ready) begin
        n_checks++;
        if (stat_idx >= acc_q.size()) begin
          n_fail++; $display("FAIL rand_status_extra: got status tag=%0d with %0d accepted", stat_tag, acc_q.size());
        end else begin
          j = acc_q[stat_idx];
          eerr = !desc_ok(j);
          eto  = eerr ? 1'b0 : cur_to;
          if ({stat_tag, stat_timeout, stat_err} !== {j.tag, eto, eerr}) begin
            n_fail++; $display("FAIL rand_status_%0d: got tag=%0d to=%b err=%b expected %0d %b %b",
                               stat_idx, stat_tag, stat_timeout, stat_err, j.tag, eto, eerr);
          end
        end
        stat_idx++;
      end
      step(); cyc++;
    end
    mvu_done = 1'b0; stat_ready = 1'b0; timeout_cycles = '0;
    n_checks++;
    if (stat_idx != n) begin n_fail++; $display("FAIL rand_complete: got %0d reports expected %0d", stat_idx, n); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_fill_overflow();
    test_timeout();
    test_invalid();
    test_backpressure();
    test_random();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
